// File: rtl/dest_ip_pkg.sv
// Shared definitions for the destination-IP match table and its access controller.
package dest_ip_pkg;

  // Width of one table entry; the table itself is built from the same value.
  localparam int unsigned TBL_ENTRY_WIDTH = 32;

  // Number of entries in the destination-IP match table.
  localparam int unsigned TBL_DEPTH = 32;

  // Controller sequencing states (3-bit encoding).
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    H_WR     = 3'd1,
    H_RD     = 3'd2,
    H_DONE   = 3'd3,
    CLR_WR   = 3'd4,
    CLR_NEXT = 3'd5,
    C_DONE   = 3'd6
  } tbl_state_t;

endpackage

// File: rtl/ack_timer.sv
// Ack wait counter: cleared by load, counts while enabled, flags the last wait cycle.
module ack_timer #(
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic AXI_ACLK,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic expire
);

  localparam int unsigned CNT_W = $clog2(ACK_TIMEOUT + 1);

  logic [CNT_W-1:0] count;

  assign expire = (count == CNT_W'(ACK_TIMEOUT - 1));

  // Wait-cycle counter; saturates at the expiry value until reloaded.
  always_ff @(posedge AXI_ACLK) begin
    if (reset || load) begin
      count <= '0;
    end else if (en && !expire) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/dest_ip_tbl_ctrl.sv
// Destination-IP match table access sequencer: host read/write and bulk clear.
module dest_ip_tbl_ctrl
  import dest_ip_pkg::*;
#(
  parameter int unsigned C_S_AXI_DATA_WIDTH = TBL_ENTRY_WIDTH,
  parameter int unsigned TBL_ADDR_WIDTH     = 5,
  parameter int unsigned ACK_TIMEOUT        = 15
) (
  input  logic                          AXI_ACLK,
  input  logic                          reset,
  // host register path
  input  logic                          host_wr_req,
  input  logic                          host_rd_req,
  input  logic [TBL_ADDR_WIDTH-1:0]     host_addr,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] host_wr_data,
  output logic [C_S_AXI_DATA_WIDTH-1:0] host_rd_data,
  output logic                          host_done,
  output logic                          host_err,
  // bulk clear
  input  logic                          clear_start,
  output logic                          clear_busy,
  output logic                          clear_done,
  // table interface
  output logic                          tbl_wr_req,
  output logic                          tbl_rd_req,
  output logic [TBL_ADDR_WIDTH-1:0]     tbl_wr_addr,
  output logic [TBL_ADDR_WIDTH-1:0]     tbl_rd_addr,
  output logic [C_S_AXI_DATA_WIDTH-1:0] tbl_wr_data,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] tbl_rd_data,
  input  logic                          tbl_wr_ack,
  input  logic                          tbl_rd_ack
);

  tbl_state_t                state;
  tbl_state_t                state_nxt;
  logic                      clear_pend;
  logic                      clr_err;
  logic [TBL_ADDR_WIDTH-1:0] clr_idx;

  logic waiting;
  logic ack_seen;
  logic tmr_expire;
  logic tmr_load;
  logic timed_out;
  logic clr_last;

  assign clr_last = (clr_idx == '1);

  ack_timer #(
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) u_ack_timer (
    .AXI_ACLK (AXI_ACLK),
    .reset    (reset),
    .load     (tmr_load),
    .en       (waiting),
    .expire   (tmr_expire)
  );

  // Next-state and wait/ack qualification; acks are only honoured in their matching wait state.
  always_comb begin
    state_nxt = state;
    waiting   = 1'b0;
    ack_seen  = 1'b0;
    case (state)
      IDLE: begin
        if (clear_start || clear_pend) begin
          state_nxt = CLR_WR;
        end else if (host_wr_req) begin
          state_nxt = H_WR;
        end else if (host_rd_req) begin
          state_nxt = H_RD;
        end
      end
      H_WR: begin
        waiting  = 1'b1;
        ack_seen = tbl_wr_ack;
        if (tbl_wr_ack || tmr_expire) state_nxt = H_DONE;
      end
      H_RD: begin
        waiting  = 1'b1;
        ack_seen = tbl_rd_ack;
        if (tbl_rd_ack || tmr_expire) state_nxt = H_DONE;
      end
      CLR_WR: begin
        waiting  = 1'b1;
        ack_seen = tbl_wr_ack;
        if (tbl_wr_ack || tmr_expire) state_nxt = CLR_NEXT;
      end
      CLR_NEXT: begin
        state_nxt = clr_last ? C_DONE : CLR_WR;
      end
      H_DONE:  state_nxt = IDLE;
      C_DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    timed_out = waiting && tmr_expire && !ack_seen;
    // Reload on every state change so each wait starts counting from zero.
    tmr_load  = !waiting || (state_nxt != state);
  end

  // FSM state, registered table/host outputs and clear bookkeeping.
  always_ff @(posedge AXI_ACLK) begin
    if (reset) begin
      state        <= IDLE;
      clear_pend   <= 1'b0;
      clr_err      <= 1'b0;
      clr_idx      <= '0;
      host_rd_data <= '0;
      host_done    <= 1'b0;
      host_err     <= 1'b0;
      clear_busy   <= 1'b0;
      clear_done   <= 1'b0;
      tbl_wr_req   <= 1'b0;
      tbl_rd_req   <= 1'b0;
      tbl_wr_addr  <= '0;
      tbl_rd_addr  <= '0;
      tbl_wr_data  <= '0;
    end else begin
      state      <= state_nxt;
      // Requests follow the next state, so they drop the cycle after the ack or expiry.
      tbl_wr_req <= (state_nxt == H_WR) || (state_nxt == CLR_WR);
      tbl_rd_req <= (state_nxt == H_RD);
      host_done  <= (state_nxt == H_DONE);
      host_err   <= ((state_nxt == H_DONE) && timed_out) ||
                    ((state_nxt == C_DONE) && clr_err);
      clear_done <= (state_nxt == C_DONE);
      clear_busy <= (state_nxt == CLR_WR) || (state_nxt == CLR_NEXT);

      if (state == IDLE && state_nxt == H_WR) begin
        tbl_wr_addr <= host_addr;
        tbl_wr_data <= host_wr_data;
      end
      if (state == IDLE && state_nxt == H_RD) begin
        tbl_rd_addr <= host_addr;
      end

      if (state_nxt == CLR_WR && state != CLR_WR) begin
        clear_pend  <= 1'b0;
        tbl_wr_data <= '0;
        if (state == IDLE) begin
          clr_err     <= 1'b0;
          tbl_wr_addr <= clr_idx;
        end else begin
          clr_idx     <= clr_idx + 1'b1;
          tbl_wr_addr <= clr_idx + 1'b1;
        end
      end else if (clear_start && state != IDLE && !clear_busy) begin
        clear_pend <= 1'b1;
      end

      if (state == CLR_WR && timed_out) begin
        clr_err <= 1'b1;
      end
      if (state == C_DONE) begin
        clr_idx <= '0;
      end

      if (state == H_RD && tbl_rd_ack) begin
        host_rd_data <= tbl_rd_data;
      end
    end
  end

endmodule

// File: tb/tb_dest_ip_tbl_ctrl.sv
// Self-checking bench for dest_ip_tbl_ctrl with a behavioural table and reference memory.
module tb_dest_ip_tbl_ctrl;

  localparam int ACK_TIMEOUT = 15;

  logic        AXI_ACLK = 1'b0;
  logic        reset;
  logic        host_wr_req, host_rd_req;
  logic [4:0]  host_addr;
  logic [31:0] host_wr_data, host_rd_data;
  logic        host_done, host_err;
  logic        clear_start, clear_busy, clear_done;
  logic        tbl_wr_req, tbl_rd_req;
  logic [4:0]  tbl_wr_addr, tbl_rd_addr;
  logic [31:0] tbl_wr_data, tbl_rd_data;
  logic        tbl_wr_ack, tbl_rd_ack;

  dest_ip_tbl_ctrl #(
    .C_S_AXI_DATA_WIDTH(32),
    .TBL_ADDR_WIDTH(5),
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut (
    .AXI_ACLK(AXI_ACLK), .reset(reset),
    .host_wr_req(host_wr_req), .host_rd_req(host_rd_req), .host_addr(host_addr),
    .host_wr_data(host_wr_data), .host_rd_data(host_rd_data),
    .host_done(host_done), .host_err(host_err),
    .clear_start(clear_start), .clear_busy(clear_busy), .clear_done(clear_done),
    .tbl_wr_req(tbl_wr_req), .tbl_rd_req(tbl_rd_req),
    .tbl_wr_addr(tbl_wr_addr), .tbl_rd_addr(tbl_rd_addr),
    .tbl_wr_data(tbl_wr_data), .tbl_rd_data(tbl_rd_data),
    .tbl_wr_ack(tbl_wr_ack), .tbl_rd_ack(tbl_rd_ack)
  );

  always #5 AXI_ACLK = ~AXI_ACLK;

  int checks = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Behavioural table: ack after ack_lat cycles of req, one-cycle ack pulse.
  logic [31:0] tbl_mem [32];
  int          ack_lat = 1;
  bit          ack_en = 1'b1;
  int          acnt = 0;
  int          both_hi = 0;
  logic [4:0]  wlog_addr [$];
  logic [31:0] wlog_data [$];

  initial begin
    tbl_wr_ack = 1'b0;
    tbl_rd_ack = 1'b0;
    tbl_rd_data = '0;
  end

  always @(posedge AXI_ACLK) begin
    if (tbl_wr_req && tbl_rd_req) both_hi++;
    if (tbl_wr_ack || tbl_rd_ack) begin
      tbl_wr_ack <= 1'b0;
      tbl_rd_ack <= 1'b0;
      acnt <= 0;
    end else if (ack_en && (tbl_wr_req || tbl_rd_req)) begin
      if (acnt >= ack_lat - 1) begin
        acnt <= 0;
        if (tbl_wr_req) begin
          tbl_wr_ack <= 1'b1;
          tbl_mem[tbl_wr_addr] <= tbl_wr_data;
          wlog_addr.push_back(tbl_wr_addr);
          wlog_data.push_back(tbl_wr_data);
        end else begin
          tbl_rd_ack <= 1'b1;
          tbl_rd_data <= tbl_mem[tbl_rd_addr];
        end
      end else begin
        acnt <= acnt + 1;
      end
    end else begin
      acnt <= 0;
    end
  end

  // Reference contents of the table as the host should see them.
  logic [31:0] ref_mem [32];
  logic [31:0] last_rd_exp = '0;

  // One host access starting from a negedge; latency counted in cycles after the sampling edge.
  task automatic host_op(input bit wr, input logic [4:0] a, input logic [31:0] d,
                         input bit with_clr, input int bound,
                         output int lat, output bit err, output int wrq_cyc,
                         output logic [4:0] seen_addr, output bit clr_before);
    lat = 0; err = 1'b0; wrq_cyc = 0; seen_addr = '0; clr_before = 1'b0;
    host_addr = a; host_wr_data = d;
    host_wr_req = wr; host_rd_req = !wr; clear_start = with_clr;
    while (1) begin
      @(negedge AXI_ACLK);
      clear_start = 1'b0;
      lat++;
      if (clear_done) clr_before = 1'b1;
      if (tbl_wr_req) begin
        wrq_cyc++;
        seen_addr = tbl_wr_addr;
      end
      if (host_done) begin
        err = host_err;
        break;
      end
      if (lat >= bound) begin
        $display("FAIL host_op_wait got=no_done exp=done_within_%0d", bound);
        failures++;
        break;
      end
    end
    host_wr_req = 1'b0;
    host_rd_req = 1'b0;
  endtask

  initial begin
    int lat, wq, n, cnt, bad;
    bit err, cb, found;
    logic [4:0] sa, a;
    logic [31:0] d;

    for (int i = 0; i < 32; i++) begin
      tbl_mem[i] = '0;
      ref_mem[i] = '0;
    end
    reset = 1'b1;
    host_wr_req = 1'b0; host_rd_req = 1'b0; host_addr = '0; host_wr_data = '0;
    clear_start = 1'b0;
    repeat (3) @(negedge AXI_ACLK);

    // Reset state
    check_val("rst_host_done", {31'b0, host_done}, 32'd0);
    check_val("rst_host_err", {31'b0, host_err}, 32'd0);
    check_val("rst_clear_busy", {31'b0, clear_busy}, 32'd0);
    check_val("rst_clear_done", {31'b0, clear_done}, 32'd0);
    check_val("rst_reqs", {30'b0, tbl_wr_req, tbl_rd_req}, 32'd0);
    check_val("rst_rd_data", host_rd_data, 32'd0);
    check_val("rst_wr_addr", {27'b0, tbl_wr_addr}, 32'd0);
    reset = 1'b0;
    @(negedge AXI_ACLK);

    // Directed host write then read of entry 5
    host_op(1'b1, 5'd5, 32'h0A00_0001, 1'b0, 50, lat, err, wq, sa, cb);
    ref_mem[5] = 32'h0A00_0001;
    check_val("wr5_latency", lat, 32'd3);
    check_val("wr5_err", {31'b0, err}, 32'd0);
    check_val("wr5_req_cycles", wq, 32'd2);
    check_val("wr5_addr", {27'b0, sa}, 32'd5);
    @(negedge AXI_ACLK);
    host_op(1'b0, 5'd5, '0, 1'b0, 50, lat, err, wq, sa, cb);
    last_rd_exp = ref_mem[5];
    check_val("rd5_data", host_rd_data, last_rd_exp);
    check_val("rd5_latency", lat, 32'd3);
    @(negedge AXI_ACLK);

    // Bulk clear over a table full of ones
    for (int i = 0; i < 32; i++) tbl_mem[i] = 32'hFFFF_FFFF;
    wlog_addr.delete(); wlog_data.delete();
    clear_start = 1'b1;
    n = 0;
    while (1) begin
      @(negedge AXI_ACLK);
      clear_start = 1'b0;
      n++;
      if (clear_done || n >= 300) break;
    end
    for (int i = 0; i < 32; i++) ref_mem[i] = '0;
    check_val("clr_cycles", n, 32'd97);
    check_val("clr_err", {31'b0, host_err}, 32'd0);
    check_val("clr_nwrites", wlog_addr.size(), 32'd32);
    bad = 0;
    for (int i = 0; i < wlog_addr.size(); i++)
      if (wlog_addr[i] != 5'(i) || wlog_data[i] != 32'd0) bad++;
    check_val("clr_write_seq", bad, 32'd0);
    cnt = 0;
    repeat (6) begin
      @(negedge AXI_ACLK);
      if (clear_done) cnt++;
    end
    check_val("clr_done_once", cnt, 32'd0);
    host_op(1'b0, 5'd31, '0, 1'b0, 50, lat, err, wq, sa, cb);
    last_rd_exp = ref_mem[31];
    check_val("rd31_after_clr", host_rd_data, last_rd_exp);
    @(negedge AXI_ACLK);

    // Clear and host write requested in the same IDLE cycle
    d = $urandom;
    host_op(1'b1, 5'd7, d, 1'b1, 400, lat, err, wq, sa, cb);
    ref_mem[7] = d;
    check_val("race_clr_first", {31'b0, cb}, 32'd1);
    check_val("race_latency", lat, 32'd101);
    check_val("race_err", {31'b0, err}, 32'd0);
    @(negedge AXI_ACLK);
    host_op(1'b0, 5'd7, '0, 1'b0, 50, lat, err, wq, sa, cb);
    last_rd_exp = ref_mem[7];
    check_val("race_rd7", host_rd_data, last_rd_exp);
    @(negedge AXI_ACLK);

    // Read timeout with ack held low
    ack_en = 1'b0;
    host_op(1'b0, 5'd3, '0, 1'b0, 50, lat, err, wq, sa, cb);
    check_val("to_latency", lat, ACK_TIMEOUT + 1);
    check_val("to_err", {31'b0, err}, 32'd1);
    check_val("to_rd_data_kept", host_rd_data, last_rd_exp);
    @(negedge AXI_ACLK);
    check_val("to_rd_req_low", {31'b0, tbl_rd_req}, 32'd0);
    ack_en = 1'b1;
    @(negedge AXI_ACLK);

    // Reset in the middle of a bulk clear
    clear_start = 1'b1;
    found = 1'b0;
    n = 0;
    while (n < 200) begin
      @(negedge AXI_ACLK);
      clear_start = 1'b0;
      n++;
      if (tbl_wr_req && tbl_wr_addr == 5'd10) begin
        found = 1'b1;
        break;
      end
    end
    check_val("mid_found_idx10", {31'b0, found}, 32'd1);
    check_val("mid_busy", {31'b0, clear_busy}, 32'd1);
    reset = 1'b1;
    @(negedge AXI_ACLK);
    reset = 1'b0;
    check_val("mid_reqs_low", {30'b0, tbl_wr_req, tbl_rd_req}, 32'd0);
    check_val("mid_busy_low", {31'b0, clear_busy}, 32'd0);
    cnt = 0;
    repeat (120) begin
      @(negedge AXI_ACLK);
      if (clear_done || clear_busy) cnt++;
    end
    check_val("mid_no_clear_done", cnt, 32'd0);
    for (int i = 0; i < 10; i++) ref_mem[i] = '0;

    // Randomised host traffic with varying table ack latency
    for (int k = 0; k < 60; k++) begin
      ack_lat = $urandom_range(1, 3);
      a = 5'($urandom_range(0, 31));
      d = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        host_op(1'b1, a, d, 1'b0, 50, lat, err, wq, sa, cb);
        ref_mem[a] = d;
        check_val("rnd_wr_latency", lat, ack_lat + 2);
        check_val("rnd_wr_addr", {27'b0, sa}, {27'b0, a});
      end else begin
        host_op(1'b0, a, '0, 1'b0, 50, lat, err, wq, sa, cb);
        last_rd_exp = ref_mem[a];
        check_val("rnd_rd_latency", lat, ack_lat + 2);
        check_val("rnd_rd_data", host_rd_data, last_rd_exp);
      end
      check_val("rnd_err", {31'b0, err}, 32'd0);
      repeat ($urandom_range(1, 3)) @(negedge AXI_ACLK);
    end

    check_val("req_exclusive", both_hi, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "time limit");
  end

endmodule
